// File: rtl/multicycle_sequencer.sv
// Moore control FSM for the multicycle 32-bit datapath: walks fetch/decode/execute/memory/
// write-back steps and emits the packed control word, with stall, halt, illegal-op and instret.
module multicycle_sequencer #(
  parameter int unsigned INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               opcode,
  input  logic                     stall,
  output logic [15:0]              output_signal,
  output logic [3:0]               state,
  output logic                     halted,
  output logic                     illegal_op,
  output logic                     retire,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StWbR     = 4'd4,
    StWbI     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StHalt    = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    OpR, OpI, OpLw, OpSw, OpBeq, OpJ, OpHalt, OpIllegal
  } op_class_e;

  state_e                   state_q, state_d, state_next;
  logic                     illegal_q, illegal_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  op_class_e                op_class;
  logic [15:0]              word;
  logic                     retire_raw;
  logic                     gate;

  always_comb begin
    op_class = OpIllegal;
    casez (opcode)
      6'b00????: op_class = OpR;
      6'b01????: op_class = OpI;
      6'b100000: op_class = OpLw;
      6'b100001: op_class = OpSw;
      6'b100010: op_class = OpBeq;
      6'b110000: op_class = OpJ;
      6'b111111: op_class = OpHalt;
      default:   op_class = OpIllegal;
    endcase
  end

  // Raw Moore word/retire per state; stall and reset gating is applied afterwards.
  always_comb begin
    word       = 16'h0000;
    retire_raw = 1'b0;
    state_next = StFetch;
    case (state_q)
      StFetch: begin
        word       = 16'h5218;
        state_next = StDecode;
      end
      StDecode: begin
        word = 16'h0008;
        case (op_class)
          OpR:       state_next = StExecR;
          OpI:       state_next = StExecI;
          OpLw, OpSw: state_next = StMemAddr;
          OpBeq:     state_next = StBranch;
          OpJ:       state_next = StJump;
          OpHalt:    state_next = StHalt;
          default:   state_next = StFetch;
        endcase
        retire_raw = (op_class == OpHalt) || (op_class == OpIllegal);
      end
      StExecR: begin
        word       = 16'h0044;
        state_next = StWbR;
      end
      StExecI: begin
        word       = 16'h004C;
        state_next = StWbI;
      end
      StWbR: begin
        word       = 16'h0003;
        retire_raw = 1'b1;
      end
      StWbI: begin
        word       = 16'h0002;
        retire_raw = 1'b1;
      end
      StMemAddr: begin
        word       = 16'h000C;
        state_next = (op_class == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        word       = 16'h3000;
        state_next = StMemWb;
      end
      StMemWb: begin
        word       = 16'h0402;
        retire_raw = 1'b1;
      end
      StMemWr: begin
        word       = 16'h2800;
        retire_raw = 1'b1;
      end
      StBranch: begin
        word       = 16'h80A4;
        retire_raw = 1'b1;
      end
      StJump: begin
        word       = 16'h4100;
        retire_raw = 1'b1;
      end
      StHalt: begin
        word       = 16'h0000;
        state_next = StHalt;
      end
      default: begin
        word       = 16'h0000;
        state_next = StFetch;
      end
    endcase
  end

  always_comb begin
    gate          = reset || stall;
    output_signal = gate ? 16'h0000 : word;
    retire        = !gate && retire_raw;
    halted        = !reset && (state_q == StHalt);
    state         = state_q;
    illegal_op    = illegal_q;
    instret       = instret_q;
    state_d       = stall ? state_q : state_next;
    illegal_d     = illegal_q ||
                    (!stall && (state_q == StDecode) && (op_class == OpIllegal));
    instret_d     = instret_q + INSTRET_WIDTH'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer; narrow instret so wrap is reachable.
module tb_multicycle_sequencer;

  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          stall;
  logic [15:0]   output_signal;
  logic [3:0]    state;
  logic          halted;
  logic          illegal_op;
  logic          retire;
  logic [IW-1:0] instret;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_sequencer #(.INSTRET_WIDTH(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .stall         (stall),
    .output_signal (output_signal),
    .state         (state),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .retire        (retire),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stl;
    logic [5:0]    op;
    logic [3:0]    st;
    logic [15:0]   word;
    logic          ret;
    logic          hlt;
    logic          ill;
    logic [IW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic stl, input logic [5:0] op, input logic [3:0] st,
                     input logic [15:0] word, input logic ret, input logic hlt,
                     input logic ill, input logic [IW-1:0] cnt);
    vec_t v;
    v.stl = stl; v.op = op; v.st = st; v.word = word;
    v.ret = ret; v.hlt = hlt; v.ill = ill; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    opcode = 6'h00;

    // Inputs are driven at the falling edge; each row gives the outputs expected before the
    // following rising edge.
    //   stl op     st  word      ret hlt ill cnt
    add(0, 6'h02, 0,  16'h5218, 0, 0, 0, 0);   // R-type
    add(0, 6'h02, 1,  16'h0008, 0, 0, 0, 0);
    add(0, 6'h02, 2,  16'h0044, 0, 0, 0, 0);
    add(0, 6'h02, 4,  16'h0003, 1, 0, 0, 0);
    add(0, 6'h20, 0,  16'h5218, 0, 0, 0, 1);   // LW
    add(0, 6'h20, 1,  16'h0008, 0, 0, 0, 1);
    add(0, 6'h20, 6,  16'h000C, 0, 0, 0, 1);
    add(0, 6'h20, 7,  16'h3000, 0, 0, 0, 1);
    add(0, 6'h20, 8,  16'h0402, 1, 0, 0, 1);
    add(0, 6'h21, 0,  16'h5218, 0, 0, 0, 2);   // SW
    add(0, 6'h21, 1,  16'h0008, 0, 0, 0, 2);
    add(0, 6'h21, 6,  16'h000C, 0, 0, 0, 2);
    add(0, 6'h21, 9,  16'h2800, 1, 0, 0, 2);
    add(0, 6'h22, 0,  16'h5218, 0, 0, 0, 3);   // BEQ
    add(0, 6'h22, 1,  16'h0008, 0, 0, 0, 3);
    add(0, 6'h22, 10, 16'h80A4, 1, 0, 0, 3);
    add(0, 6'h30, 0,  16'h5218, 0, 0, 0, 4);   // J
    add(0, 6'h30, 1,  16'h0008, 0, 0, 0, 4);
    add(0, 6'h30, 11, 16'h4100, 1, 0, 0, 4);
    add(0, 6'h2A, 0,  16'h5218, 0, 0, 0, 5);   // illegal
    add(0, 6'h2A, 1,  16'h0008, 1, 0, 0, 5);
    add(0, 6'h15, 0,  16'h5218, 0, 0, 1, 6);   // I-type, sticky illegal
    add(0, 6'h15, 1,  16'h0008, 0, 0, 1, 6);
    add(0, 6'h15, 3,  16'h004C, 0, 0, 1, 6);
    add(0, 6'h15, 5,  16'h0002, 1, 0, 1, 6);
    add(0, 6'h20, 0,  16'h5218, 0, 0, 1, 7);   // LW, stalled in MEM_RD
    add(0, 6'h20, 1,  16'h0008, 0, 0, 1, 7);
    add(0, 6'h20, 6,  16'h000C, 0, 0, 1, 7);
    add(1, 6'h20, 7,  16'h0000, 0, 0, 1, 7);
    add(1, 6'h20, 7,  16'h0000, 0, 0, 1, 7);
    add(1, 6'h20, 7,  16'h0000, 0, 0, 1, 7);
    add(0, 6'h20, 7,  16'h3000, 0, 0, 1, 7);
    add(0, 6'h20, 8,  16'h0402, 1, 0, 1, 7);
    add(0, 6'h3F, 0,  16'h5218, 0, 0, 1, 8);   // HALT, stalled in DECODE
    add(1, 6'h3F, 1,  16'h0000, 0, 0, 1, 8);
    add(0, 6'h3F, 1,  16'h0008, 1, 0, 1, 8);
    add(0, 6'h3F, 12, 16'h0000, 0, 1, 1, 9);
    add(1, 6'h3F, 12, 16'h0000, 0, 1, 1, 9);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset word", 32'(output_signal), 32'h0);
    check("reset retire", 32'(retire), 32'd0);
    check("reset instret", 32'(instret), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset  = 1'b0;
      stall  = vecs[i].stl;
      opcode = vecs[i].op;
      #1;
      check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("v%0d word", i), 32'(output_signal), 32'(vecs[i].word));
      check($sformatf("v%0d retire", i), 32'(retire), 32'(vecs[i].ret));
      check($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].hlt));
      check($sformatf("v%0d illegal_op", i), 32'(illegal_op), 32'(vecs[i].ill));
      check($sformatf("v%0d instret", i), 32'(instret), 32'(vecs[i].cnt));
    end

    // HALT holds for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stall = 1'b0;
      #1;
      check($sformatf("halt%0d state", i), 32'(state), 32'd12);
      check($sformatf("halt%0d word", i), 32'(output_signal), 32'h0);
      check($sformatf("halt%0d halted", i), 32'(halted), 32'd1);
    end
    check("halt instret", 32'(instret), 32'd9);

    // One reset edge leaves HALT.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst word", 32'(output_signal), 32'h0);
    check("rst retire", 32'(retire), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    opcode = 6'h02;
    #1;
    check("post-halt state", 32'(state), 32'd0);
    check("post-halt halted", 32'(halted), 32'd0);
    check("post-halt instret", 32'(instret), 32'd0);
    check("post-halt illegal_op", 32'(illegal_op), 32'd0);

    // Reset mid-instruction wins over stall.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid state", 32'(state), 32'd2);
    reset = 1'b1;
    stall = 1'b1;
    #1;
    check("mid rst word", 32'(output_signal), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    opcode = 6'h2A;
    #1;
    check("mid rst state", 32'(state), 32'd0);
    check("mid rst instret", 32'(instret), 32'd0);

    // Sixteen 2-cycle illegal instructions wrap the 4-bit counter.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("wrap%0d retire", k), 32'(retire), 32'd1);
      @(negedge clk);
      #1;
      check($sformatf("wrap%0d instret", k), 32'(instret), 32'(k % 16));
    end
    check("wrap illegal_op", 32'(illegal_op), 32'd1);
    check("wrap state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Moore-style control FSM that sequences the multicycle 32-bit datapath through fetch, decode, execute, memory and write-back steps. It takes the 6-bit opcode from the instruction register and emits the 16-bit packed control word that drives the datapath's muxes and write enables. It also provides stall support, halt and illegal-opcode status, and a retired-instruction counter.

## Interface
- `INSTRET_WIDTH`, default 32: width of the retired-instruction counter.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `opcode`, in, 6: IR[31:26]; stable outside FETCH.
- `stall`, in, 1: hold the current state; control word forced to 0.
- `output_signal`, out, 16: packed control word.
  - [15] PCWriteCond, [14] PCWrite, [13] IorD, [12] MemRead, [11] MemWrite, [10] MemtoReg, [9] IRWrite.
  - [8:7] PCSource, [6:5] ALUOp, [4:3] ALUSrcB, [2] ALUSrcA, [1] RegWrite, [0] RegDst.
- `state`, out, 4: current state encoding (debug).
- `halted`, out, 1: high while in HALT.
- `illegal_op`, out, 1: sticky; set on decode of an undefined opcode.
- `retire`, out, 1: one-cycle pulse in the final cycle of each instruction.
- `instret`, out, INSTRET_WIDTH: count of retired instructions.

## Operation
Field meanings:
- ALUSrcA: 0 = PC, 1 = A register.
- ALUSrcB: 00 = B register, 01 = sign-extended immediate, 10 = zero-extended immediate, 11 = constant 1.
- ALUOp: 00 = add, 01 = subtract, 10 = function from IR[29:26], 11 unused.
- PCSource: 00 = ALU result, 01 = ALUOut register, 10 = jump immediate.
- IorD: 0 = PC, 1 = ALU.

Opcode classes:
- 00xxxx: R-type.
- 01xxxx: I-type, sign-extended immediate.
- 100000: LW.
- 100001: SW.
- 100010: BEQ.
- 110000: J.
- 111111: HALT.
- All other opcodes are illegal.

States, with encoding, control word, and next state:
- FETCH (0), 0x5218: fetch the instruction, write IR, PC <= PC+1. Next: DECODE.
- DECODE (1), 0x0008: compute the branch target PC+sext into ALUOut. Next by opcode: EXEC_R, EXEC_I, MEM_ADDR (LW/SW), BRANCH, JUMP or HALT. Illegal opcode goes to FETCH and sets `illegal_op`.
- EXEC_R (2), 0x0044. Next: WB_R.
- EXEC_I (3), 0x004C. Next: WB_I.
- WB_R (4), 0x0003. Next: FETCH.
- WB_I (5), 0x0002. Next: FETCH.
- MEM_ADDR (6), 0x000C. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD (7), 0x3000. Next: MEM_WB.
- MEM_WB (8), 0x0402. Next: FETCH.
- MEM_WR (9), 0x2800. Next: FETCH.
- BRANCH (10), 0x80A4. Next: FETCH.
- JUMP (11), 0x4100. Next: FETCH.
- HALT (12), 0x0000. Stays in HALT until reset.
- Encodings 13–15 are unreachable. If entered, the control word is 0x0000 and the next state is FETCH.

Retire rules:
- `retire` is high in WB_R, WB_I, MEM_WB, MEM_WR, BRANCH and JUMP.
- `retire` is also high in DECODE when the opcode is HALT or illegal.
- `instret` increments on the same edge `retire` is high and wraps modulo 2^INSTRET_WIDTH.

## Timing
- Reset is sampled at the clock edge. After that edge: state = FETCH, `instret` = 0, `illegal_op` = 0, `halted` = 0.
- While `reset` is high, `output_signal` = 0 and `retire` = 0.
- Reset takes priority over `stall` and over any state, including HALT or mid-instruction.
- `output_signal`, `halted` and `retire` are combinational functions of the state register, gated by `stall` and `reset`; they change no earlier than the state changes.
- Latency in cycles, FETCH through last state:
  - R-type: 4. I-type: 4. LW: 5. SW: 4.
  - BEQ: 3. J: 3. HALT: 2. Illegal: 2.
- When `stall` = 1:
  - State holds.
  - `output_signal` = 0 and `retire` = 0.
  - `instret` and `illegal_op` are unchanged.
  - When `stall` drops, the held state's word reappears in full.
- Stall during HALT has no visible effect.
- `illegal_op` stays set until reset; further illegal opcodes keep it at 1.

## Test plan
- Reset, then R-type opcode 000010 with no stall:
  - `output_signal` sequence is 0x5218, 0x0008, 0x0044, 0x0003, then 0x5218.
  - `retire` is high in the 4th cycle only; `instret` = 1.
- LW (100000):
  - States go 0, 1, 6, 7, 8, 0 with words 0x5218, 0x0008, 0x000C, 0x3000, 0x0402.
  - SW (100001) goes 0, 1, 6, 9 with last word 0x2800.
- BEQ (100010), then J (110000):
  - Words are 0x5218, 0x0008, 0x80A4, then 0x5218, 0x0008, 0x4100.
  - `instret` = 2 afterwards.
- Opcode 101010:
  - DECODE returns to FETCH; `illegal_op` = 1 and `retire` pulses.
  - A following legal instruction leaves `illegal_op` = 1.
- HALT (111111):
  - State 12 is reached and `halted` = 1; the state holds for 20 cycles with the word at 0x0000.
  - Asserting `reset` for one edge gives state 0, `halted` = 0, `instret` = 0.
- `stall` held for 3 cycles while in MEM_RD:
  - `output_signal` = 0 and state = 7 throughout the stall.
  - After release, the word is 0x3000 for one cycle, then MEM_WB.
  - `instret` is incremented exactly once.
